// File: rtl/subneg_pkg.sv
// Shared types and helpers for the SUBNEG fetch/execute controller.
// Build option: define SUBNEG_LEQ_EN to branch on zero results too (SUBLEQ).
package subneg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    FETCH_C,
    LOAD_A,
    LOAD_B,
    STORE,
    HALT
  } state_t;

  localparam int INSTR_WORDS = 3;

  // Branch condition from the sign and zero flags of mem[B] - mem[A].
  function automatic logic branch_take(input logic neg, input logic zero);
`ifdef SUBNEG_LEQ_EN
    return neg | zero;
`else
    return neg | (1'b0 & zero);
`endif
  endfunction

endpackage

// File: rtl/subneg_alu.sv
// Combinational subtract-and-test: result = vb - va, take = branch condition.
// The branch condition honours SUBNEG_LEQ_EN through subneg_pkg::branch_take.
module subneg_alu
  import subneg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] va,
  input  logic [WIDTH-1:0] vb,
  output logic [WIDTH-1:0] result,
  output logic             take
);

  assign result = vb - va;
  assign take   = branch_take(result[WIDTH-1], result == '0);

endmodule

// File: rtl/subneg_ctrl.sv
// Multi-cycle fetch/execute controller for the SUBNEG one-instruction core.
// Define SUBNEG_LEQ_EN for SUBLEQ branch semantics (take on zero as well).
module subneg_ctrl
  import subneg_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             halted
);

  // Handshake: a request (rd_en or wr_en, never both) with its addr/wdata is
  // held unchanged until an edge with mem_ready=1, which completes it; ready
  // with no request pending has no effect.
  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, c, va, vb;
  logic [WIDTH-1:0] addr_nxt, wdata_nxt, pc_nxt;
  logic             rd_nxt, wr_nxt;
  logic             done;
  logic [WIDTH-1:0] alu_vb, alu_result;
  logic             alu_take;

  assign done   = mem_ready & (mem_rd_en | mem_wr_en);
  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);

  // In LOAD_B the subtraction uses the word arriving now, so wdata is ready
  // when STORE begins; in STORE it uses the latched vb to decide the branch.
  assign alu_vb = (state == LOAD_B) ? mem_rdata : vb;

  subneg_alu #(.WIDTH(WIDTH)) u_alu (
    .va     (va),
    .vb     (alu_vb),
    .result (alu_result),
    .take   (alu_take)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    rd_nxt    = mem_rd_en;
    wr_nxt    = mem_wr_en;
    pc_nxt    = pc;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH_A;
          addr_nxt  = pc;
          rd_nxt    = 1'b1;
        end
      end
      FETCH_A: begin
        if (done) begin
          state_nxt = FETCH_B;
          addr_nxt  = pc + WIDTH'(1);
        end
      end
      FETCH_B: begin
        if (done) begin
          state_nxt = FETCH_C;
          addr_nxt  = pc + WIDTH'(2);
        end
      end
      FETCH_C: begin
        if (done) begin
          state_nxt = LOAD_A;
          addr_nxt  = a;
        end
      end
      LOAD_A: begin
        if (done) begin
          state_nxt = LOAD_B;
          addr_nxt  = b;
        end
      end
      LOAD_B: begin
        if (done) begin
          state_nxt = STORE;
          addr_nxt  = b;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b1;
          wdata_nxt = alu_result;
        end
      end
      STORE: begin
        if (done) begin
          wr_nxt    = 1'b0;
          wdata_nxt = '0;
          if (alu_take && (c == pc)) begin
            state_nxt = HALT;
            addr_nxt  = '0;
          end else begin
            state_nxt = FETCH_A;
            pc_nxt    = alu_take ? c : pc + WIDTH'(INSTR_WORDS);
            addr_nxt  = pc_nxt;
            rd_nxt    = 1'b1;
          end
        end
      end
      HALT: begin
        rd_nxt = 1'b0;
        wr_nxt = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      va        <= '0;
      vb        <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_rd_en <= rd_nxt;
      mem_wr_en <= wr_nxt;
      if (done) begin
        case (state)
          FETCH_A: a  <= mem_rdata;
          FETCH_B: b  <= mem_rdata;
          FETCH_C: c  <= mem_rdata;
          LOAD_A:  va <= mem_rdata;
          LOAD_B:  vb <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_subneg_ctrl.sv
// Self-checking bench for subneg_ctrl: behavioural memory, directed scenarios
// and randomized single instructions checked against an arithmetic model.
module tb_subneg_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] pc;
  logic       busy;
  logic       halted;

  int errors = 0;
  int checks = 0;

  subneg_ctrl #(.WIDTH(8), .RESET_PC(8'h00)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [7:0] exp_q [$];
  int         rdy_mode = 0;   // 0: always ready, 1: two wait cycles, 2: random
  int         age = 0;
  logic       rnd_ready = 1'b1;
  logic       clr_req = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic [7:0] load_data = 8'h00;

  assign mem_rdata = mem[mem_addr];

  always_comb begin
    mem_ready = 1'b1;
    if (rdy_mode == 1) mem_ready = (age == 2);
    else if (rdy_mode == 2) mem_ready = rnd_ready;
  end

  always @(posedge clock) begin
    if (clr_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (reset && mem_wr_en && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (!reset || !(mem_rd_en || mem_wr_en) || mem_ready) age <= 0;
    else age <= age + 1;
    rnd_ready <= 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    load_en = 1'b1; load_addr = addr; load_data = data;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // Holds reset low while the program is loaded, then releases it.
  task automatic setup(input logic [7:0] pa, input logic [7:0] pb, input logic [7:0] pcc,
                       input logic [7:0] va, input logic [7:0] vb);
    reset = 1'b0; start = 1'b0;
    clr_req = 1'b1;
    @(negedge clock);
    clr_req = 1'b0;
    poke(8'h00, pa); poke(8'h01, pb); poke(8'h02, pcc);
    poke(pa, va); poke(pb, vb);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Runs until pc moves or the core halts; counts busy cycles on the way.
  task automatic run_instr(input bit do_start, input int max_cyc,
                           output int busy_cyc, output bit timed_out);
    logic [7:0] pc0;
    pc0 = pc; busy_cyc = 0; timed_out = 1'b1;
    if (do_start) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end else begin
      start = 1'b1;
    end
    for (int i = 0; i < max_cyc; i++) begin
      if (pc !== pc0 || halted === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (busy === 1'b1) busy_cyc++;
      @(negedge clock);
      start = 1'b0;
    end
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", {mem_rd_en, mem_wr_en}); end
    checks++; if ({mem_addr, mem_wdata} !== 16'h0000) begin errors++; $display("FAIL reset_bus: got %h want 0000", {mem_addr, mem_wdata}); end
    start = 1'b0; reset = 1'b1;
    @(negedge clock);
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b want 0", mem_rd_en); end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h00) begin
      errors++; $display("FAIL first_fetch: got rd=%b addr=%h want rd=1 addr=00", mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_no_branch();
    int n, base; bit to;
    setup(8'h0A, 8'h0B, 8'h06, 8'd3, 8'd5);
    base = wr_data_q.size();
    run_instr(1'b1, 100, n, to);
    checks++; if (to) begin errors++; $display("FAIL nobr_timeout: pc=%h", pc); end
    checks++; if (n != 6) begin errors++; $display("FAIL nobr_cycles: got %0d want 6", n); end
    checks++; if (wr_data_q.size() != base + 1) begin errors++; $display("FAIL nobr_wcount: got %0d want %0d", wr_data_q.size(), base + 1); end
    else begin
      checks++; if (wr_addr_q[base] !== 8'h0B || wr_data_q[base] !== 8'h02) begin
        errors++; $display("FAIL nobr_write: got %h<=%h want 0b<=02", wr_addr_q[base], wr_data_q[base]);
      end
    end
    checks++; if (pc !== 8'h03) begin errors++; $display("FAIL nobr_pc: got %h want 03", pc); end
  endtask

  task automatic test_branch();
    int n, base; bit to;
    setup(8'h0A, 8'h0B, 8'h06, 8'd7, 8'd5);
    base = wr_data_q.size();
    run_instr(1'b1, 100, n, to);
    checks++; if (to) begin errors++; $display("FAIL br_timeout: pc=%h", pc); end
    checks++; if (mem[8'h0B] !== 8'hFE) begin errors++; $display("FAIL br_mem: got %h want fe", mem[8'h0B]); end
    checks++; if (wr_data_q.size() != base + 1) begin errors++; $display("FAIL br_wcount: got %0d want %0d", wr_data_q.size(), base + 1); end
    checks++; if (pc !== 8'h06) begin errors++; $display("FAIL br_pc: got %h want 06", pc); end
  endtask

  task automatic test_zero();
    int n; bit to; logic [7:0] exp_pc;
`ifdef SUBNEG_LEQ_EN
    exp_pc = 8'h06;
`else
    exp_pc = 8'h03;
`endif
    setup(8'h0A, 8'h0B, 8'h06, 8'd5, 8'd5);
    run_instr(1'b1, 100, n, to);
    checks++; if (to) begin errors++; $display("FAIL zero_timeout: pc=%h", pc); end
    checks++; if (mem[8'h0B] !== 8'h00) begin errors++; $display("FAIL zero_mem: got %h want 00", mem[8'h0B]); end
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL zero_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_wait();
    int n, base; bit have_prev; logic [17:0] prev, cur; logic [7:0] pc0;
    setup(8'h0A, 8'h0B, 8'h06, 8'd3, 8'd5);
    rdy_mode = 1;
    base = wr_data_q.size();
    pc0 = pc; n = 0; have_prev = 1'b0; prev = '0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pc !== pc0) break;
      if (busy === 1'b1) n++;
      cur = {mem_rd_en, mem_wr_en, mem_addr, mem_wdata};
      if (have_prev) begin
        checks++; if (cur !== prev) begin errors++; $display("FAIL wait_stable: got %h want %h", cur, prev); end
      end
      have_prev = (mem_rd_en || mem_wr_en) && !mem_ready;
      prev = cur;
      @(negedge clock);
    end
    checks++; if (n != 18) begin errors++; $display("FAIL wait_cycles: got %0d want 18", n); end
    checks++; if (pc !== 8'h03) begin errors++; $display("FAIL wait_pc: got %h want 03", pc); end
    checks++; if (mem[8'h0B] !== 8'h02 || wr_data_q.size() != base + 1) begin
      errors++; $display("FAIL wait_write: got mem=%h count=%0d want 02 count=%0d", mem[8'h0B], wr_data_q.size(), base + 1);
    end

    // Second pass: reset lands while STORE is waiting for ready.
    setup(8'h0A, 8'h0B, 8'h06, 8'd3, 8'd5);
    base = wr_data_q.size();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 100 && mem_wr_en !== 1'b1; i++) @(negedge clock);
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL wait_store_seen: got wr=%b want 1", mem_wr_en); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({mem_rd_en, mem_wr_en, busy, halted} !== 4'b0000) begin
      errors++; $display("FAIL rst_store_ctl: got %b want 0000", {mem_rd_en, mem_wr_en, busy, halted});
    end
    checks++; if ({pc, mem_addr, mem_wdata} !== 24'h000000) begin
      errors++; $display("FAIL rst_store_bus: got %h want 000000", {pc, mem_addr, mem_wdata});
    end
    checks++; if (mem[8'h0B] !== 8'h05 || wr_data_q.size() != base) begin
      errors++; $display("FAIL rst_store_nowrite: got mem=%h count=%0d want 05 count=%0d", mem[8'h0B], wr_data_q.size(), base);
    end
    reset = 1'b1;
    rdy_mode = 0;
  endtask

  task automatic test_halt();
    int n, base; bit to;
    setup(8'h0A, 8'h0B, 8'h00, 8'd1, 8'd0);
    base = wr_data_q.size();
    run_instr(1'b1, 100, n, to);
    checks++; if (to) begin errors++; $display("FAIL halt_timeout: pc=%h", pc); end
    checks++; if (halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL halt_flags: got h=%b b=%b want h=1 b=0", halted, busy); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL halt_pc: got %h want 00", pc); end
    checks++; if (wr_data_q.size() != base + 1 || mem[8'h0B] !== 8'hFF) begin
      errors++; $display("FAIL halt_write: got mem=%h count=%0d want ff count=%0d", mem[8'h0B], wr_data_q.size(), base + 1);
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_sticky: cycle %0d got rd=%b wr=%b h=%b want 0 0 1", i, mem_rd_en, mem_wr_en, halted);
      end
      @(negedge clock);
    end
  endtask

  // Branch to 0xFE, whose third word wraps to address 0x00; start while busy is ignored.
  task automatic test_wrap();
    int n, base; bit to;
    setup(8'h10, 8'h11, 8'hFE, 8'd1, 8'd0);
    poke(8'hFE, 8'h12); poke(8'hFF, 8'h13);
    poke(8'h12, 8'd1);  poke(8'h13, 8'd5);
    base = wr_data_q.size();
    run_instr(1'b1, 100, n, to);
    checks++; if (to || pc !== 8'hFE) begin errors++; $display("FAIL wrap_jump: got pc=%h to=%b want fe", pc, to); end
    run_instr(1'b0, 100, n, to);
    checks++; if (n != 6) begin errors++; $display("FAIL wrap_cycles: got %0d want 6", n); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL wrap_pc: got %h want 01", pc); end
    checks++; if (wr_data_q.size() != base + 2 || mem[8'h13] !== 8'h04) begin
      errors++; $display("FAIL wrap_write: got mem=%h count=%0d want 04 count=%0d", mem[8'h13], wr_data_q.size(), base + 2);
    end
  endtask

  task automatic test_random();
    int n, base; bit to, take, exp_halt;
    logic [7:0] pa, pb, pcc, va, vb, mem_a, diff, exp_pc, exp_data, got;
    for (int it = 0; it < 24; it++) begin
      pa  = 8'($urandom_range(16, 255));
      pb  = ($urandom_range(0, 5) == 0) ? pa : 8'($urandom_range(16, 255));
      pcc = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      va  = 8'($urandom_range(0, 255));
      vb  = ($urandom_range(0, 5) == 0) ? va : 8'($urandom_range(0, 255));
      // Reference: one SUBNEG step from pc=0 on the program just loaded.
      mem_a = (pa == pb) ? vb : va;
      diff  = vb - mem_a;
`ifdef SUBNEG_LEQ_EN
      take = ($signed(diff) <= 0);
`else
      take = ($signed(diff) < 0);
`endif
      exp_halt = take && (pcc == 8'h00);
      exp_pc   = exp_halt ? 8'h00 : (take ? pcc : 8'h03);
      exp_data = diff;
      exp_q.push_back(exp_data);
      setup(pa, pb, pcc, va, vb);
      rdy_mode = 2;
      base = wr_data_q.size();
      run_instr(1'b1, 400, n, to);
      rdy_mode = 0;
      got = exp_q.pop_front();
      checks++; if (to) begin errors++; $display("FAIL rnd_timeout: iter %0d pc=%h", it, pc); end
      checks++; if (wr_data_q.size() != base + 1) begin
        errors++; $display("FAIL rnd_wcount: iter %0d got %0d want %0d", it, wr_data_q.size(), base + 1);
      end else begin
        checks++; if (wr_addr_q[base] !== pb || wr_data_q[base] !== got) begin
          errors++; $display("FAIL rnd_write: iter %0d got %h<=%h want %h<=%h", it, wr_addr_q[base], wr_data_q[base], pb, got);
        end
      end
      checks++; if (pc !== exp_pc || halted !== exp_halt) begin
        errors++; $display("FAIL rnd_pc: iter %0d got pc=%h h=%b want pc=%h h=%b", it, pc, halted, exp_pc, exp_halt);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_no_branch();
    test_branch();
    test_zero();
    test_wait();
    test_halt();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subneg_ctrl.md
Name: subneg_ctrl

Overview:
- Multi-cycle fetch/execute controller for the SUBNEG one-instruction core.
- Sits directly upstream of the operand and PC registers. Drives the shared data memory through a single ready-handshaked port.
- Each instruction is three words at PC: A, B, C. It computes mem[B] = mem[B] - mem[A], then jumps to C if the result is negative, otherwise goes to PC+3.

Parameters:
WIDTH, 8, data and address width in bits (same width for both).
RESET_PC, 0, PC value loaded at reset.

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous reset, active-low
start  input  1  one-cycle pulse that begins execution from IDLE
mem_rdata  input  WIDTH  read data; valid when mem_ready=1 during a read
mem_ready  input  1  memory accepts or completes the current access this cycle
mem_addr  output  WIDTH  access address
mem_rd_en  output  1  read request
mem_wr_en  output  1  write request
mem_wdata  output  WIDTH  write data
pc  output  WIDTH  current program counter
busy  output  1  high in every state except IDLE and HALT
halted  output  1  high in HALT

Behaviour:
- Reset: reset=0 sampled at a clock edge forces state=IDLE and pc=RESET_PC.
  - Outputs go to 0: mem_addr, mem_wdata, mem_rd_en, mem_wr_en, busy, halted.
  - Internal latches a, b, c are also cleared to 0.
  - Reset dominates any state. An in-flight access is abandoned and no write completes.
- States: IDLE, FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, STORE, HALT.
- IDLE: start=1 moves to FETCH_A on the next cycle. Otherwise stays in IDLE.
- Memory states: outputs are registered, and each state holds exactly one request.
  - FETCH_A: addr=pc, read. Latch a on completion.
  - FETCH_B: addr=pc+1, read. Latch b on completion.
  - FETCH_C: addr=pc+2, read. Latch c on completion.
  - LOAD_A: addr=a, read. Latch operand va on completion.
  - LOAD_B: addr=b, read. Latch operand vb on completion.
  - STORE: addr=b, wdata=vb-va, write.
- Handshake rules:
  - At most one of mem_rd_en and mem_wr_en is high at any time.
  - The request, mem_addr and mem_wdata stay stable until an edge where mem_ready=1.
  - The state advances on that edge.
  - mem_ready while no request is asserted is ignored.
- Arithmetic:
  - result = vb - va, modulo 2^WIDTH (two's complement; no overflow flag).
  - neg = result[WIDTH-1].
  - pc+1, pc+2 and pc+3 all wrap modulo 2^WIDTH.
- On STORE completion:
  - take = neg.
  - next_pc = take ? c : pc+3.
  - If take and c == pc, go to HALT; pc is unchanged.
  - Otherwise pc = next_pc and go to FETCH_A.
- HALT: sticky until reset. start is ignored. No memory requests are issued.
- start while busy is ignored.
- Latency with zero wait states (mem_ready tied to 1): 6 cycles per instruction. The first request is asserted in the cycle after start is sampled.

Optional Feature:
- Macro: SUBNEG_LEQ_EN.
- Defined: the block behaves as SUBLEQ, with take = neg | (result == 0). The halt rule uses this same take.
- Undefined: take = neg only, so a zero result falls through to pc+3.

Decomposition:
- subneg_pkg holds:
  - typedef enum state_t (the 8 states above)
  - localparam INSTR_WORDS = 3
  - helper function for the branch condition, honouring SUBNEG_LEQ_EN
- One natural sub-module: subneg_alu. Combinational; inputs va and vb; outputs result and take.
- Everything else (FSM, latches, PC) lives in subneg_ctrl.

Test Plan:
All scenarios use WIDTH=8, RESET_PC=0 and a behavioural memory model; zero wait states unless stated.
1. Reset: hold reset=0 for 2 cycles with start=1 -> pc=0x00, busy=0, halted=0, no mem_rd_en or mem_wr_en. After release, a start pulse leads to mem_rd_en=1 at addr 0x00 on the next cycle.
2. No branch: mem[0..2]={0x0A,0x0B,0x06}, mem[0x0A]=3, mem[0x0B]=5, pulse start -> one write of 0x02 to 0x0B, pc=0x03 exactly 6 cycles after start.
3. Branch taken: same program with mem[0x0A]=7 -> mem[0x0B]=0xFE, pc=0x06.
4. Zero result: mem[0x0A]=mem[0x0B]=5 -> mem[0x0B]=0. pc=0x03 without SUBNEG_LEQ_EN; pc=0x06 with it.
5. Wait states and reset: mem_ready low for 2 cycles before each completion -> addr, enables and wdata stable throughout, instruction finishes in 18 cycles with the same result as scenario 2. Then repeat with reset=0 asserted during STORE wait -> memory not written, all outputs at reset values.
6. Halt: mem[0..2]={0x0A,0x0B,0x00}, mem[0x0A]=1, mem[0x0B]=0 -> write 0xFF, halted=1, busy=0, pc=0x00. No further requests for 20 cycles despite a start pulse.
